// File: rtl/id_ex_pipe.sv
// Decode->execute pipeline register with load-use bubble insertion, branch flush and global hold.
// Optional hazard statistics counters are enabled by defining HAZARD_STATS_EN.
module id_ex_pipe #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned RF_WIDTH   = 5,
  parameter int unsigned CTRL_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_d,
  input  logic [DATA_WIDTH-1:0] pc_d,
  input  logic [DATA_WIDTH-1:0] rd1_d,
  input  logic [DATA_WIDTH-1:0] rd2_d,
  input  logic [DATA_WIDTH-1:0] imm_d,
  input  logic [RF_WIDTH-1:0]   rs1_d,
  input  logic [RF_WIDTH-1:0]   rs2_d,
  input  logic [RF_WIDTH-1:0]   rd_d,
  input  logic                  use_rs1_d,
  input  logic                  use_rs2_d,
  input  logic                  mem_read_d,
  input  logic [CTRL_WIDTH-1:0] ctrl_d,
  input  logic                  flush_e,
  input  logic                  hold_e,
  output logic                  valid_e,
  output logic [DATA_WIDTH-1:0] pc_e,
  output logic [DATA_WIDTH-1:0] rd1_e,
  output logic [DATA_WIDTH-1:0] rd2_e,
  output logic [DATA_WIDTH-1:0] imm_e,
  output logic [RF_WIDTH-1:0]   rs1_e,
  output logic [RF_WIDTH-1:0]   rs2_e,
  output logic [RF_WIDTH-1:0]   rd_e,
  output logic                  mem_read_e,
  output logic [CTRL_WIDTH-1:0] ctrl_e,
  output logic                  stall_fd
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]           bubble_cnt,
  output logic [31:0]           flush_cnt
`endif
);

  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_pc;
  logic [DATA_WIDTH-1:0] r_rd1;
  logic [DATA_WIDTH-1:0] r_rd2;
  logic [DATA_WIDTH-1:0] r_imm;
  logic [RF_WIDTH-1:0]   r_rs1;
  logic [RF_WIDTH-1:0]   r_rs2;
  logic [RF_WIDTH-1:0]   r_rd;
  logic                  r_mem_read;
  logic [CTRL_WIDTH-1:0] r_ctrl;

  logic w_rs1_match;
  logic w_rs2_match;
  logic w_lu_hazard;
  logic w_bubble;

  // Only a live load with a non-x0 destination can create a load-use hazard.
  always_comb begin
    w_rs1_match = use_rs1_d && (rs1_d == r_rd);
    w_rs2_match = use_rs2_d && (rs2_d == r_rd);
    w_lu_hazard = r_valid && r_mem_read && (r_rd != '0) && valid_d &&
                  (w_rs1_match || w_rs2_match);
    w_bubble    = w_lu_hazard && !flush_e && !hold_e;
    stall_fd    = w_bubble;
  end

  always_ff @(posedge clk) begin
    if (rst || flush_e || (w_lu_hazard && !hold_e)) begin
      r_valid    <= 1'b0;
      r_pc       <= '0;
      r_rd1      <= '0;
      r_rd2      <= '0;
      r_imm      <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rd       <= '0;
      r_mem_read <= 1'b0;
      r_ctrl     <= '0;
    end else if (!hold_e) begin
      r_valid    <= valid_d;
      r_pc       <= pc_d;
      r_rd1      <= rd1_d;
      r_rd2      <= rd2_d;
      r_imm      <= imm_d;
      r_rs1      <= rs1_d;
      r_rs2      <= rs2_d;
      r_rd       <= valid_d ? rd_d : '0;
      r_mem_read <= valid_d & mem_read_d;
      r_ctrl     <= valid_d ? ctrl_d : '0;
    end
  end

  always_comb begin
    valid_e    = r_valid;
    pc_e       = r_pc;
    rd1_e      = r_rd1;
    rd2_e      = r_rd2;
    imm_e      = r_imm;
    rs1_e      = r_rs1;
    rs2_e      = r_rs2;
    rd_e       = r_rd;
    mem_read_e = r_mem_read;
    ctrl_e     = r_ctrl;
  end

`ifdef HAZARD_STATS_EN
  logic [31:0] r_bubble_cnt;
  logic [31:0] r_flush_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bubble_cnt <= '0;
      r_flush_cnt  <= '0;
    end else begin
      if (w_bubble && (r_bubble_cnt != '1))
        r_bubble_cnt <= r_bubble_cnt + 32'd1;
      if (flush_e && (r_flush_cnt != '1))
        r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  always_comb begin
    bubble_cnt = r_bubble_cnt;
    flush_cnt  = r_flush_cnt;
  end
`endif

endmodule
